// File: rtl/prog_ctr_pkg.sv
// Shared types, default widths and the wrap-increment helper for the program counter.
// The optional return-address stack is enabled by defining PC_RAS_EN.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_RUN  = 2'd1,
    PC_DONE = 2'd2
  } pc_state_t;

  localparam int DEF_L         = 10;
  localparam int DEF_NUM_TGT   = 4;
  localparam int DEF_OFF_W     = 8;
  localparam int DEF_STK_DEPTH = 4;

  // Increment modulo 2^width; width up to 32 bits.
  function automatic logic [31:0] next_pc_inc(input logic [31:0] pc, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (pc + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses: DEPTH entries of W bits with push/pop and full/empty.
// Only instantiated when PC_RAS_EN is defined.
module pc_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] sp_q;
  logic [PW-1:0] top_idx;
  logic [W-1:0]  mem_q [DEPTH];

  assign top_idx  = sp_q - 1'b1;
  assign top_data = mem_q[top_idx[AW-1:0]];
  assign full     = (sp_q == PW'(DEPTH));
  assign empty    = (sp_q == '0);

  // Pop wins if both are requested; the caller never asks for both anyway.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sp_q <= '0;
    end else if (pop && !empty) begin
      sp_q <= sp_q - 1'b1;
    end else if (push && !full) begin
      mem_q[sp_q[AW-1:0]] <= push_data;
      sp_q                <= sp_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_ctr_gen.sv
// Fetch-stage program counter with run control, stall, branch-target bank and jumps.
// Define PC_RAS_EN to add the Call/Ret return-address stack and the StkErr flag.
module prog_ctr_gen
  import prog_ctr_pkg::*;
#(
  parameter int L         = DEF_L,
  parameter int NUM_TGT   = DEF_NUM_TGT,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Halt,
  input  logic                       Stall,
  input  logic                       TgtWr,
  input  logic [$clog2(NUM_TGT)-1:0] TgtSel,
  input  logic                       OffsetEn,
  input  logic [OFF_W-1:0]           Offset,
  input  logic                       JmpEq,
  input  logic                       JmpNe,
  input  logic                       JmpU,
  input  logic [$clog2(NUM_TGT)-1:0] JmpSel,
  input  logic                       Zero,
  input  logic                       Call,
  input  logic                       Ret,
  output logic [L-1:0]               ProgCtr,
  output logic                       Running,
  output logic                       Done,
  output logic                       StkErr,
  output logic [1:0]                 dbg_state
);

  pc_state_t    state_q, state_d;
  logic [L-1:0] pc_q, pc_d;
  logic [L-1:0] pc_inc;
  logic [L-1:0] off_ext;
  logic [L-1:0] cap_val;
  logic [L-1:0] tgt_q [NUM_TGT];
  logic         cap_en;
  logic         jmp_taken;
  logic         clr_stk;
  logic         push;
  logic         pop;
  logic         err_set;

  assign pc_inc    = L'(next_pc_inc(32'(pc_q), L));
  assign off_ext   = OffsetEn ? L'($signed(Offset)) : '0;
  assign cap_val   = pc_q + off_ext;
  assign jmp_taken = JmpU | (JmpEq & Zero) | (JmpNe & ~Zero);

`ifdef PC_RAS_EN
  logic [L-1:0] stk_top;
  logic         stk_full;
  logic         stk_empty;

  pc_ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (L)
  ) u_ret_stack (
    .clk       (Clk),
    .reset     (Reset),
    .clear     (clr_stk),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StkErr <= 1'b0;
    end else if (err_set) begin
      StkErr <= 1'b1;
    end
  end
`else
  localparam int unused_stk_depth = STK_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{Call, Ret, clr_stk, push, pop, err_set};
  assign StkErr     = 1'b0;
`endif

  // Jumps and calls read tgt_q before this cycle's capture lands.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cap_en  = 1'b0;
    clr_stk = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (state_q)
      PC_IDLE, PC_DONE: begin
        if (Start) begin
          state_d = PC_RUN;
          pc_d    = '0;
          clr_stk = 1'b1;
        end
      end
      PC_RUN: begin
        if (Start) begin
          pc_d    = '0;
          clr_stk = 1'b1;
        end else if (!Stall) begin
          cap_en = TgtWr;
          if (Halt) begin
            state_d = PC_DONE;
          end
`ifdef PC_RAS_EN
          else if (Ret) begin
            if (stk_empty) begin
              pc_d    = pc_inc;
              err_set = 1'b1;
            end else begin
              pc_d = stk_top;
              pop  = 1'b1;
            end
          end else if (Call) begin
            if (stk_full) begin
              pc_d    = pc_inc;
              err_set = 1'b1;
            end else begin
              pc_d = tgt_q[JmpSel];
              push = 1'b1;
            end
          end
`endif
          else if (jmp_taken) begin
            pc_d = tgt_q[JmpSel];
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        state_d = PC_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= PC_IDLE;
      pc_q    <= '0;
      for (int i = 0; i < NUM_TGT; i++) begin
        tgt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (cap_en) begin
        tgt_q[TgtSel] <= cap_val;
      end
    end
  end

  assign ProgCtr   = pc_q;
  assign Running   = (state_q == PC_RUN);
  assign Done      = (state_q == PC_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_ctr_gen.sv
// Bench for prog_ctr_gen: directed scenarios plus random stimulus against a behavioural model.
// Stack scenarios are selected by PC_RAS_EN, matching the DUT build.
module tb_prog_ctr_gen;

  localparam int L         = 10;
  localparam int NUM_TGT   = 4;
  localparam int OFF_W     = 8;
  localparam int STK_DEPTH = 2;
  localparam int SW        = $clog2(NUM_TGT);
  localparam int PC_MASK   = (1 << L) - 1;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic             Clk;
  logic             Reset, Start, Halt, Stall, TgtWr, OffsetEn;
  logic [SW-1:0]    TgtSel, JmpSel;
  logic [OFF_W-1:0] Offset;
  logic             JmpEq, JmpNe, JmpU, Zero, Call, Ret;
  logic [L-1:0]     ProgCtr;
  logic             Running, Done, StkErr;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 done
  int m_state;
  int m_pc;
  int m_tgt [NUM_TGT];
  int m_stk [$];
  bit m_err;

  prog_ctr_gen #(
    .L(L), .NUM_TGT(NUM_TGT), .OFF_W(OFF_W), .STK_DEPTH(STK_DEPTH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .TgtWr(TgtWr), .TgtSel(TgtSel), .OffsetEn(OffsetEn), .Offset(Offset),
    .JmpEq(JmpEq), .JmpNe(JmpNe), .JmpU(JmpU), .JmpSel(JmpSel), .Zero(Zero),
    .Call(Call), .Ret(Ret), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .StkErr(StkErr), .dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clear_inputs();
    Reset = 0; Start = 0; Halt = 0; Stall = 0; TgtWr = 0; TgtSel = '0;
    OffsetEn = 0; Offset = '0; JmpEq = 0; JmpNe = 0; JmpU = 0; JmpSel = '0;
    Zero = 0; Call = 0; Ret = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    int cap_v;
    if (Reset) begin
      m_state = 0; m_pc = 0; m_err = 0; m_stk.delete();
      foreach (m_tgt[i]) m_tgt[i] = 0;
    end else if (Start) begin
      m_state = 1; m_pc = 0; m_stk.delete();
    end else if (m_state == 1 && !Stall) begin
      cap_v = (m_pc + (OffsetEn ? int'($signed(Offset)) : 0)) & PC_MASK;
      if (Halt) begin
        m_state = 2;
      end else if (RAS && Ret) begin
        if (m_stk.size() == 0) begin
          m_pc = (m_pc + 1) & PC_MASK; m_err = 1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (RAS && Call) begin
        if (m_stk.size() == STK_DEPTH) begin
          m_pc = (m_pc + 1) & PC_MASK; m_err = 1;
        end else begin
          m_stk.push_back((m_pc + 1) & PC_MASK);
          m_pc = m_tgt[JmpSel];
        end
      end else if (JmpU || (JmpEq && Zero) || (JmpNe && !Zero)) begin
        m_pc = m_tgt[JmpSel];
      end else begin
        m_pc = (m_pc + 1) & PC_MASK;
      end
      if (TgtWr) m_tgt[TgtSel] = cap_v;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 2000 && m_pc != target; k++) step();
  endtask

  task automatic start_prog();
    Start = 1; step(); Start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1; step(); step(); Reset = 0;
    n_tests++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", ProgCtr); end
    n_tests++; if (Running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", Running); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", Done); end
    n_tests++; if (StkErr !== 1'b0) begin n_fail++; $display("FAIL reset_stkerr: got %0b expected 0", StkErr); end
    step(); step();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got pc=%0d run=%0b expected pc=0 run=0", ProgCtr, Running); end
  endtask

  task automatic test_free_run();
    start_prog();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b1) begin n_fail++; $display("FAIL start: got pc=%0d run=%0b expected pc=0 run=1", ProgCtr, Running); end
    for (int i = 1; i <= 5; i++) begin
      step();
      n_tests++; if (ProgCtr !== L'(i)) begin n_fail++; $display("FAIL free_run: got %0d expected %0d", ProgCtr, i); end
    end
    Reset = 1; step(); Reset = 0;
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin n_fail++; $display("FAIL reset_mid_run: got pc=%0d run=%0b expected pc=0 run=0", ProgCtr, Running); end
  endtask

  task automatic test_capture_jump();
    start_prog(); run_to(20);
    TgtWr = 1; TgtSel = 2; OffsetEn = 1; Offset = 8'hFC; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd21) begin n_fail++; $display("FAIL capture_inc: got %0d expected 21", ProgCtr); end
    JmpNe = 1; Zero = 0; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd16) begin n_fail++; $display("FAIL jmp_ne_taken: got %0d expected 16", ProgCtr); end
    JmpEq = 1; Zero = 0; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd17) begin n_fail++; $display("FAIL jmp_eq_not_taken: got %0d expected 17", ProgCtr); end
    JmpEq = 1; Zero = 1; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd16) begin n_fail++; $display("FAIL jmp_eq_taken: got %0d expected 16", ProgCtr); end
  endtask

  task automatic test_same_cycle();
    start_prog(); run_to(7);
    TgtWr = 1; TgtSel = 1; step(); clear_inputs();
    run_to(30);
    TgtWr = 1; TgtSel = 1; JmpU = 1; JmpSel = 1; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd7) begin n_fail++; $display("FAIL same_cycle_old_tgt: got %0d expected 7", ProgCtr); end
    JmpU = 1; JmpSel = 1; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd30) begin n_fail++; $display("FAIL same_cycle_new_tgt: got %0d expected 30", ProgCtr); end
  endtask

  task automatic test_wrap();
    start_prog();
    TgtWr = 1; TgtSel = 3; OffsetEn = 1; Offset = 8'hFE; step(); clear_inputs();
    JmpU = 1; JmpSel = 3; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd1022) begin n_fail++; $display("FAIL wrap_tgt: got %0d expected 1022", ProgCtr); end
    step();
    n_tests++; if (ProgCtr !== 10'd1023) begin n_fail++; $display("FAIL wrap_top: got %0d expected 1023", ProgCtr); end
    step();
    n_tests++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", ProgCtr); end
  endtask

  task automatic test_stall();
    start_prog(); run_to(5);
    TgtWr = 1; TgtSel = 0; step(); clear_inputs();
    run_to(9);
    Stall = 1; TgtWr = 1; TgtSel = 0; JmpU = 1; JmpSel = 0; Halt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (ProgCtr !== 10'd9 || Running !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got pc=%0d run=%0b expected pc=9 run=1", ProgCtr, Running); end
    end
    clear_inputs(); JmpU = 1; JmpSel = 0; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd5) begin n_fail++; $display("FAIL stall_tgt_kept: got %0d expected 5", ProgCtr); end
  endtask

  task automatic test_halt();
    start_prog(); run_to(12);
    Halt = 1; step(); clear_inputs();
    n_tests++; if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'd12) begin n_fail++; $display("FAIL halt: got pc=%0d done=%0b run=%0b expected pc=12 done=1 run=0", ProgCtr, Done, Running); end
    for (int i = 0; i < 10; i++) begin
      JmpU = 1; TgtWr = 1; JmpSel = SW'($urandom_range(0, NUM_TGT-1)); Halt = 1'($urandom_range(0, 1));
      step();
      n_tests++; if (ProgCtr !== 10'd12 || Done !== 1'b1) begin n_fail++; $display("FAIL done_frozen: got pc=%0d done=%0b expected pc=12 done=1", ProgCtr, Done); end
    end
    clear_inputs(); start_prog();
    n_tests++; if (ProgCtr !== 10'd0 || Running !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL restart_from_done: got pc=%0d run=%0b done=%0b expected 0 1 0", ProgCtr, Running, Done); end
  endtask

  task automatic test_stack();
    clear_inputs(); Reset = 1; step(); Reset = 0;
    start_prog();
    TgtWr = 1; TgtSel = 2; OffsetEn = 1; Offset = 8'd40; step(); clear_inputs();
    run_to(5);
`ifdef PC_RAS_EN
    Call = 1; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd40) begin n_fail++; $display("FAIL call: got %0d expected 40", ProgCtr); end
    Ret = 1; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd6) begin n_fail++; $display("FAIL ret: got %0d expected 6", ProgCtr); end
    Call = 1; JmpSel = 2; step(); step();
    n_tests++; if (ProgCtr !== 10'd40 || StkErr !== 1'b0) begin n_fail++; $display("FAIL call_fill: got pc=%0d err=%0b expected pc=40 err=0", ProgCtr, StkErr); end
    step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd41 || StkErr !== 1'b1) begin n_fail++; $display("FAIL call_full: got pc=%0d err=%0b expected pc=41 err=1", ProgCtr, StkErr); end
    Ret = 1; Call = 1; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd41) begin n_fail++; $display("FAIL ret_beats_call: got %0d expected 41", ProgCtr); end
    Ret = 1; step();
    n_tests++; if (ProgCtr !== 10'd7) begin n_fail++; $display("FAIL ret_second: got %0d expected 7", ProgCtr); end
    step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd8 || StkErr !== 1'b1) begin n_fail++; $display("FAIL ret_empty: got pc=%0d err=%0b expected pc=8 err=1", ProgCtr, StkErr); end
`else
    Call = 1; JmpSel = 2; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd6 || StkErr !== 1'b0) begin n_fail++; $display("FAIL call_ignored: got pc=%0d err=%0b expected pc=6 err=0", ProgCtr, StkErr); end
    Ret = 1; step(); clear_inputs();
    n_tests++; if (ProgCtr !== 10'd7 || StkErr !== 1'b0) begin n_fail++; $display("FAIL ret_ignored: got pc=%0d err=%0b expected pc=7 err=0", ProgCtr, StkErr); end
`endif
  endtask

  task automatic test_random();
    clear_inputs(); Reset = 1; step(); Reset = 0;
    for (int i = 0; i < 3000; i++) begin
      Reset    = ($urandom_range(0, 199) == 0);
      Start    = ($urandom_range(0, 39) == 0);
      Halt     = ($urandom_range(0, 49) == 0);
      Stall    = ($urandom_range(0, 7) == 0);
      TgtWr    = ($urandom_range(0, 3) == 0);
      TgtSel   = SW'($urandom_range(0, NUM_TGT-1));
      OffsetEn = 1'($urandom_range(0, 1));
      Offset   = OFF_W'($urandom_range(0, 255));
      JmpEq    = ($urandom_range(0, 5) == 0);
      JmpNe    = ($urandom_range(0, 5) == 0);
      JmpU     = ($urandom_range(0, 7) == 0);
      JmpSel   = SW'($urandom_range(0, NUM_TGT-1));
      Zero     = 1'($urandom_range(0, 1));
      Call     = ($urandom_range(0, 9) == 0);
      Ret      = ($urandom_range(0, 9) == 0);
      step();
      n_tests++; if (ProgCtr !== m_pc[L-1:0]) begin n_fail++; $display("FAIL rand_pc cycle %0d: got %0d expected %0d", i, ProgCtr, m_pc); end
      n_tests++; if (Running !== (m_state == 1)) begin n_fail++; $display("FAIL rand_running cycle %0d: got %0b expected %0b", i, Running, m_state == 1); end
      n_tests++; if (Done !== (m_state == 2)) begin n_fail++; $display("FAIL rand_done cycle %0d: got %0b expected %0b", i, Done, m_state == 2); end
      n_tests++; if (StkErr !== m_err) begin n_fail++; $display("FAIL rand_stkerr cycle %0d: got %0b expected %0b", i, StkErr, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_state = 0; m_pc = 0; m_err = 0;
    foreach (m_tgt[i]) m_tgt[i] = 0;
    @(posedge Clk); #1;
    test_reset();
    test_free_run();
    test_capture_jump();
    test_same_cycle();
    test_wrap();
    test_stall();
    test_halt();
    test_stack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_ctr_gen.md
Name: prog_ctr_gen

Overview:
- Parametrised successor to the fetch-stage program counter.
- Holds an L-bit PC and a bank of NUM_TGT branch-target registers, captured relative to the PC.
- Adds run-control (idle/run/done), stall, and selectable conditional or unconditional jumps.
- Sits between the decoder/ALU flags and instruction memory; ProgCtr drives the instruction ROM address.

Parameters:
- L, 10, PC width in bits; instruction address space is 2^L.
- NUM_TGT, 4, number of branch-target registers; must be at least 2.
- OFF_W, 8, width of the signed capture offset; must be at most L.
- STK_DEPTH, 4, return-stack entries; used only with PC_RAS_EN.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin or restart the program at address 0.
- Halt  in  1  decoder saw the halt instruction.
- Stall  in  1  hold PC and all state this cycle.
- TgtWr  in  1  capture a branch target.
- TgtSel  in  $clog2(NUM_TGT)  target register written on capture.
- OffsetEn  in  1  add Offset on capture.
- Offset  in  OFF_W  signed offset, two's complement.
- JmpEq  in  1  jump if equal.
- JmpNe  in  1  jump if not equal.
- JmpU  in  1  unconditional jump.
- JmpSel  in  $clog2(NUM_TGT)  target register used by jump or call.
- Zero  in  1  ALU flag; 1 means the compared operands are equal.
- Call  in  1  push return address, then jump (PC_RAS_EN only).
- Ret  in  1  pop the return address into PC (PC_RAS_EN only).
- ProgCtr  out  L  current PC.
- Running  out  1  state is RUN.
- Done  out  1  state is DONE.
- StkErr  out  1  sticky return-stack overflow/underflow flag.

Behaviour:
- Reset: ProgCtr=0, state IDLE, all Tgt=0, Running=0, Done=0, StkErr=0, stack pointer=0.
- Reset overrides every other input, including mid-RUN.
- FSM IDLE: PC holds. Start -> RUN, PC=0.
- FSM RUN:
  - Start restarts: PC=0, stays RUN; Tgt contents kept, stack pointer cleared.
  - Halt (not stalled) -> DONE; PC holds.
- FSM DONE: PC frozen. Start -> RUN, PC=0. No other exit except Reset.
- RUN priority, highest first: Start > Stall > Halt > Ret > Call > jump > increment.
- Stall freezes PC, Tgt, stack and FSM; TgtWr is ignored while stalled.
- Jump taken when JmpU, or (JmpEq && Zero), or (JmpNe && !Zero). Taken: PC <= Tgt[JmpSel]. Otherwise PC <= PC+1.
- Increment wraps modulo 2^L: 2^L-1 -> 0.
- Capture (RUN, not stalled):
  - Tgt[TgtSel] <= ProgCtr + (OffsetEn ? sign-extend(Offset) : 0), modulo 2^L.
  - Capture may coincide with a jump.
  - A jump in the same cycle reads the pre-write value, even if TgtSel==JmpSel.
- Capture is ignored in IDLE and DONE.
- Multiple jump strobes asserted together: the taken condition is the OR of all three; the target is always Tgt[JmpSel].
- Latency: every PC change is visible on ProgCtr one cycle after the qualifying edge. No combinational path from inputs to ProgCtr.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - STK_DEPTH-entry return-address stack.
  - Call pushes PC+1 (wrapped) and jumps to Tgt[JmpSel] unconditionally.
  - Ret pops into PC.
  - Call when full: no push, no jump, PC+1, StkErr<=1.
  - Ret when empty: PC+1, StkErr<=1.
  - Call and Ret together: Ret wins, no push.
  - StkErr clears only on Reset.
- Undefined: Call/Ret ignored (ports remain), StkErr tied 0, no stack storage.

Decomposition:
- Package prog_ctr_pkg holds:
  - typedef enum pc_state_t {PC_IDLE, PC_RUN, PC_DONE}.
  - localparam default widths.
  - function next_pc_inc (wrap increment).
- Sub-module pc_ret_stack: LIFO of STK_DEPTH x L with push/pop, full/empty. Instantiated only under PC_RAS_EN.

Test Plan:
- Reset, then Start, 5 free-running cycles -> ProgCtr 0,1,2,3,4,5; Running=1. Reset asserted mid-run -> next cycle ProgCtr=0, IDLE.
- PC=20, TgtWr TgtSel=2 OffsetEn Offset=-4 -> Tgt[2]=16. Later JmpNe Zero=0 JmpSel=2 -> PC=16. JmpEq Zero=0 -> PC+1.
- PC=30, TgtWr TgtSel=1 and JmpU JmpSel=1 in the same cycle (old Tgt[1]=7) -> PC=7. Tgt[1]=30 afterwards.
- L=4: PC=15 with no jump -> PC=0. Stall held 3 cycles at PC=9 -> PC stays 9, Tgt unchanged.
- Halt at PC=12 -> Done=1, PC frozen at 12 for 10 cycles. Start -> PC=0, Running=1.
- PC_RAS_EN, STK_DEPTH=2: Call at PC=5 to Tgt=40 -> PC=40. Ret -> PC=6. Three Calls without Ret -> third does not jump, StkErr=1.
